booth_mac: RTL and testbench

Sequential signed multiply-accumulate unit computing `product = x*y + addend` with radix-2 Booth recoding, one recoding step per clock. It is the inverse companion of the team's sequential divider: given a quotient, divisor and remainder, it reconstructs the dividend (`quotient*divisor + remainder`). It is used for divider self-check and in datapaths that need a shared multiplier. It uses the same start/done handshake style as the divider.

---
 rtl/booth_mac.sv | 108 ++++++++++
 tb/tb_booth_mac.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mac.sv
// booth_mac: sequential signed multiply-accumulate, product = x*y + addend.
// Radix-2 Booth recoding, one step per clock; N steps then one add cycle.
module booth_mac #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic [2*N-1:0] addend,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, ADD} state_t;

    state_t         state_q, state_d;
    logic [N:0]     a_q, a_d;      // partial-product high half, one guard bit
    logic [N:0]     m_q, m_d;      // multiplicand, sign-extended so -M of -2^(N-1) fits
    logic [N-1:0]   q_q, q_d;      // multiplier, shifts out as product low half
    logic           q1_q, q1_d;    // Booth history bit
    logic [2*N-1:0] c_q, c_d;      // latched addend
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;
    logic           done_q, done_d;
    logic [N:0]     sum;

    assign product = product_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

    // Next-state, Booth step and final accumulate
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        q1_d      = q1_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        sum       = a_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {x[N-1], x};
                    q_d     = y;
                    c_d     = addend;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                case ({q_q[0], q1_q})
                    2'b01:   sum = a_q + m_q;
                    2'b10:   sum = a_q - m_q;
                    default: sum = a_q;
                endcase
                // arithmetic shift of {A,Q,q_1} right by one
                a_d   = {sum[N], sum[N:1]};
                q_d   = {sum[0], q_q[N-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1))
                    state_d = ADD;
            end
            ADD: begin
                product_d = {a_q[N-1:0], q_q} + c_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers, all cleared by async reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            c_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_booth_mac.sv
// tb_booth_mac: scoreboard bench; stimulus pushes expected results, a
// negedge monitor pops and compares whenever done is seen.
module tb_booth_mac;

    localparam int N  = 8;
    localparam int W2 = 2 * N;
    localparam int LAT = N + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  x, y;
    logic [W2-1:0] addend;
    logic [W2-1:0] product;
    logic          busy, done;

    booth_mac #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
        .addend(addend), .product(product), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W2-1:0] prod;
        int            cyc;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // reference model: plain signed arithmetic, wrapped to 2N bits
    function automatic logic [W2-1:0] ref_mac(input logic signed [N-1:0] a,
                                             input logic signed [N-1:0] b,
                                             input logic signed [W2-1:0] c);
        longint r;
        r = longint'(a) * longint'(b) + longint'(c);
        return r[W2-1:0];
    endfunction

    // monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_product"}, product, e.prod);
                check({e.name, "_latency"}, cyc, e.cyc);
                check({e.name, "_busy_low_in_done"}, busy, 0);
            end
        end
    end

    // drive one operation at a negedge; the next posedge samples it
    task automatic issue(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [W2-1:0] c);
        exp_t e;
        start  = 1'b1;
        x      = a;
        y      = b;
        addend = c;
        e.prod = ref_mac(a, b, c);
        e.cyc  = cyc + LAT + 1;
        e.name = nm;
        sb.push_back(e);
    endtask

    // wait for done with a cycle budget; returns number of busy cycles seen
    task automatic wait_done(input string nm, output int bcnt);
        bcnt = 0;
        for (int i = 0; i < 4 * LAT; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) return;
            if (busy) bcnt++;
        end
        check({nm, "_timeout"}, 1, 0);
    endtask

    task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [W2-1:0] c);
        int bc;
        @(negedge clk);
        issue(nm, a, b, c);
        wait_done(nm, bc);
        check({nm, "_busy_cycles"}, bc, LAT);
    endtask

    initial begin
        int bc;
        reset = 1'b1; start = 1'b0; x = '0; y = '0; addend = '0;
        repeat (2) @(negedge clk);
        check("reset_product", product, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;

        // directed cases
        run_op("x7y3a2", 8'd7, 8'd3, 16'd2);
        run_op("min_sq", 8'h80, 8'h80, 16'd0);
        run_op("neg5x6", 8'hFB, 8'd6, 16'hFFFF);
        run_op("wrap", 8'd127, 8'd127, 16'h7FFF);
        run_op("zero_x", 8'd0, 8'hFF, 16'd5);

        // restart while busy is ignored, then back-to-back start in done cycle
        @(negedge clk);
        issue("ign_first", 8'd3, 8'd4, 16'd0);
        repeat (4) begin @(negedge clk); start = 1'b0; end
        start = 1'b1; x = 8'd9;              // must be ignored
        @(negedge clk); start = 1'b0;
        wait_done("ign_first", bc);
        issue("b2b", 8'd2, 8'hFE, 16'd1);    // done cycle: block is IDLE
        wait_done("b2b", bc);
        check("b2b_busy_cycles", bc, LAT);

        // reset 4 clocks after start: no done, outputs zero
        @(negedge clk);
        issue("rst_mid", 8'd11, 8'd13, 16'd0);
        repeat (4) begin @(negedge clk); start = 1'b0; end
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rst_mid_product", product, 0);
        check("rst_mid_busy", busy, 0);
        reset = 1'b0;
        repeat (2 * LAT) @(negedge clk);     // monitor flags any stray done

        // reset landing on the ADD cycle
        @(negedge clk);
        issue("rst_add", 8'd5, 8'd5, 16'd0);
        repeat (LAT) begin @(negedge clk); start = 1'b0; end
        check("rst_add_busy_before", busy, 1);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rst_add_product", product, 0);
        check("rst_add_done", done, 0);

        // start already high at reset release: sampled on first edge
        issue("rst_start", 8'hF9, 8'hF7, 16'd10);
        reset = 1'b0;
        wait_done("rst_start", bc);

        // random MAC
        for (int i = 0; i < 30; i++) begin
            logic [N-1:0]  ra, rb;
            logic [W2-1:0] rc;
            ra = N'($urandom); rb = N'($urandom); rc = W2'($urandom);
            run_op("rand", ra, rb, rc);
        end

        // divider reconstruction: quotient*divisor + remainder == dividend
        for (int i = 0; i < 30; i++) begin
            int dd, dv, qq, rr;
            logic [N-1:0]  qv, dvv;
            logic [W2-1:0] rv;
            exp_t e;
            dd = $urandom_range(0, 255) - 128;
            do dv = $urandom_range(0, 255) - 128; while (dv == 0 || (dd == -128 && dv == -1));
            qq = dd / dv;
            rr = dd % dv;
            qv = qq[N-1:0]; dvv = dv[N-1:0]; rv = rr[W2-1:0];
            @(negedge clk);
            issue("div_recon", qv, dvv, rv);
            // override model result with the dividend itself
            e = sb.pop_back();
            e.prod = dd[W2-1:0];
            sb.push_back(e);
            wait_done("div_recon", bc);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
